pipeline_mem_arbiter: RTL and testbench
=======================================

Name: pipeline_mem_arbiter

Overview:
- Shares a single unified memory port between the instruction-fetch stage and the memory-access stage (the stage fed by the exec-to-mem pipeline register).
- Sequences each access through a small FSM and holds the fetch and memory pipeline stages stalled until their access completes.
- Data-stage requests have priority. A starvation counter guarantees that fetch makes forward progress.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush; cancels the pending or in-flight fetch result
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetched word; valid when if_done=1
if_done  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request (mem_enable of the mem stage); held until dm_done
dm_rw  in  1  1=write, 0=read
dm_width  in  1  access width, passed through
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_rdata  out  DATA_WIDTH  load data; valid when dm_done=1
dm_done  out  1  one-cycle data completion pulse
mem_req  out  1  memory-port request
mem_rw  out  1  memory-port direction
mem_width  out  1  memory-port width
mem_addr  out  ADDR_WIDTH  memory-port address
mem_wdata  out  DATA_WIDTH  memory-port write data
mem_rdata  in  DATA_WIDTH  memory-port read data
mem_ready  in  1  memory-port completion, sampled only while mem_req=1
stall_fetch  out  1  stall for the fetch-side pipeline registers
stall_mem  out  1  stall for the exec-to-mem and upstream pipeline registers

Behaviour:
Clock and reset:
- One clock clk. Reset rst is synchronous and active-high.
- On reset: state=IDLE, mem_req=0, mem_rw=0, mem_width=0, mem_addr=0, mem_wdata=0, if_done=0, dm_done=0, if_rdata=0, dm_rdata=0, starve counter=0, cancel flag=0.
- Reset mid-transaction abandons the transaction; the memory is reset in the same cycle.

States: IDLE, BUSY_IF, BUSY_DM.

IDLE arbitration (evaluated each IDLE cycle):
- Eligible requesters exclude any requester whose done pulse is asserted in the same cycle, because its request is still high for the completed access.
- If fetch is eligible and either flush=1 or starve==STARVE_LIMIT is not met, fetch may still be blocked: flush=1 blocks a fetch grant that cycle.
- Data wins if dm_req is eligible and not (if_req eligible, flush=0 and starve==STARVE_LIMIT).
- Otherwise fetch wins if if_req is eligible and flush=0.
- On a grant, latch addr/rw/width/wdata into the mem_* registers, set mem_req=1 on the next cycle, and move to BUSY_DM or BUSY_IF. Fetch grants use rw=0, width=0, wdata=0.

Busy states:
- mem_req and all mem_* outputs are held stable until the cycle in which mem_ready=1.
- In that cycle, capture mem_rdata into dm_rdata or if_rdata and clear mem_req.
- Next cycle: return to IDLE and pulse the matching done for exactly one cycle.
- Minimum latency: request at cycle N, mem_req=1 at N+1, done at N+2 (mem_ready=1 at N+1).

Flush:
- flush=1 in BUSY_IF sets the cancel flag. The memory transaction still completes, but if_done is suppressed and if_rdata is not updated. The flag is cleared on return to IDLE.
- flush has no effect on BUSY_DM or on data accesses.

Starve counter (4 bits, saturating at STARVE_LIMIT):
- Increments on each data grant while if_req=1.
- Clears on a fetch grant or whenever if_req=0.

Stall outputs (combinational):
- stall_mem = dm_req & ~dm_done.
- stall_fetch = (if_req & ~if_done) | stall_mem.

Requester contract:
- if_done and dm_done are never asserted in the same cycle.
- The done pulse is the only completion indicator; the requester may present a new request in the cycle after done.

Test Plan:
- Single load: dm_req=1, dm_addr=0x100, mem_ready held 1, mem_rdata=0xDEADBEEF -> mem_req=1 at N+1 with mem_addr=0x100; dm_done=1 and dm_rdata=0xDEADBEEF at N+2; stall_mem=1 at N..N+1 and 0 at N+2.
- Simultaneous requests, STARVE_LIMIT=4: if_req and dm_req held high, dm_req re-asserted after each dm_done -> 4 data grants, then fetch granted 5th; starve counter returns to 0.
- Wait states: a store with mem_ready low for 3 cycles -> mem_req/mem_addr/mem_wdata/mem_rw=1 held stable for 4 cycles; dm_done is a single pulse one cycle after mem_ready.
- Flush during fetch: fetch of 0x40 in BUSY_IF, flush=1 for one cycle -> transaction completes, if_done never pulses, if_rdata unchanged; a subsequent if_req to 0x80 completes normally.
- Flush in IDLE: flush=1 with if_req=1 and dm_req=0 -> no grant that cycle; grant on the following cycle.
- Reset mid-op: rst=1 while in BUSY_DM -> next cycle mem_req=0, state IDLE, dm_done=0, starve counter=0; no done pulse after release.

Source files
------------

// File: rtl/pipeline_mem_arbiter_if.sv
// Bundle of the fetch, data and unified memory-port signals around pipeline_mem_arbiter.
// master: the pipeline stages plus the memory; slave: the arbiter itself.
interface pipeline_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  flush;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_done;

   logic                  dm_req;
   logic                  dm_rw;
   logic                  dm_width;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [DATA_WIDTH-1:0] dm_rdata;
   logic                  dm_done;

   logic                  mem_req;
   logic                  mem_rw;
   logic                  mem_width;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;

   logic                  stall_fetch;
   logic                  stall_mem;

   modport master (
      output flush,
      output if_req, if_addr,
      input  if_rdata, if_done,
      output dm_req, dm_rw, dm_width, dm_addr, dm_wdata,
      input  dm_rdata, dm_done,
      input  mem_req, mem_rw, mem_width, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  stall_fetch, stall_mem
   );

   modport slave (
      input  flush,
      input  if_req, if_addr,
      output if_rdata, if_done,
      input  dm_req, dm_rw, dm_width, dm_addr, dm_wdata,
      output dm_rdata, dm_done,
      output mem_req, mem_rw, mem_width, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output stall_fetch, stall_mem
   );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and the data stage.
// Data has priority; a saturating starve counter forces a fetch grant after STARVE_LIMIT data grants.
module pipeline_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_mem_arbiter_if.slave bus
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StBusyIf = 2'd1;
   localparam logic [1:0] StBusyDm = 2'd2;

   localparam logic [3:0] StarveMax = STARVE_LIMIT[3:0];

   logic [1:0]            state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_rw_q, mem_rw_d;
   logic                  mem_width_q, mem_width_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  if_done_q, if_done_d;
   logic                  dm_done_q, dm_done_d;
   logic [3:0]            starve_q, starve_d;
   logic                  cancel_q, cancel_d;

   logic if_elig, dm_elig, starved, dm_win, if_win, in_idle;

   // A requester still holding req during its own done pulse is asking for the access just finished.
   assign if_elig = bus.if_req & ~if_done_q;
   assign dm_elig = bus.dm_req & ~dm_done_q;
   assign starved = (starve_q == StarveMax);
   assign in_idle = (state_q == StIdle);

   assign dm_win = in_idle & dm_elig & ~(if_elig & ~bus.flush & starved);
   assign if_win = in_idle & ~dm_win & if_elig & ~bus.flush;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_rw_d    = mem_rw_q;
      mem_width_d = mem_width_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      cancel_d    = cancel_q;

      case (state_q)
         StIdle: begin
            cancel_d = 1'b0;
            if (dm_win) begin
               state_d     = StBusyDm;
               mem_req_d   = 1'b1;
               mem_rw_d    = bus.dm_rw;
               mem_width_d = bus.dm_width;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
            end else if (if_win) begin
               state_d     = StBusyIf;
               mem_req_d   = 1'b1;
               mem_rw_d    = 1'b0;
               mem_width_d = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
            end
         end
         StBusyIf: begin
            if (bus.flush) begin
               cancel_d = 1'b1;
            end
            if (bus.mem_ready) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               cancel_d  = 1'b0;
               // A flush arriving in the completing cycle still cancels the result.
               if (!cancel_q && !bus.flush) begin
                  if_rdata_d = bus.mem_rdata;
                  if_done_d  = 1'b1;
               end
            end
         end
         StBusyDm: begin
            if (bus.mem_ready) begin
               state_d    = StIdle;
               mem_req_d  = 1'b0;
               dm_rdata_d = bus.mem_rdata;
               dm_done_d  = 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (!bus.if_req || if_win) begin
         starve_d = 4'd0;
      end else if (dm_win && (starve_q < StarveMax)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_width_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         starve_q    <= 4'd0;
         cancel_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_rw_q    <= mem_rw_d;
         mem_width_q <= mem_width_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         starve_q    <= starve_d;
         cancel_q    <= cancel_d;
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_rw      = mem_rw_q;
   assign bus.mem_width   = mem_width_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.dm_rdata    = dm_rdata_q;
   assign bus.if_done     = if_done_q;
   assign bus.dm_done     = dm_done_q;

   assign bus.stall_mem   = bus.dm_req & ~dm_done_q;
   assign bus.stall_fetch = (bus.if_req & ~if_done_q) | (bus.dm_req & ~dm_done_q);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter: load, wait-state store, flush cases,
// starvation release and mid-transaction reset.
module tb_pipeline_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipeline_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   pipeline_mem_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   // Step one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_rw     = 1'b0;
      bus.dm_width  = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
      check("rst_dm_done", {31'd0, bus.dm_done}, 32'd0);
      check("rst_state", {30'd0, dut.state_q}, 32'd0);
      check("rst_starve", {28'd0, dut.starve_q}, 32'd0);
      rst = 1'b0;

      // Single load with mem_ready held high
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      bus.dm_req    = 1'b1;
      bus.dm_addr   = 32'h100;
      #1;
      check("ld_stall_n", {31'd0, bus.stall_mem}, 32'd1);
      tick();
      check("ld_mem_req_n1", {31'd0, bus.mem_req}, 32'd1);
      check("ld_mem_addr_n1", bus.mem_addr, 32'h100);
      check("ld_mem_rw_n1", {31'd0, bus.mem_rw}, 32'd0);
      check("ld_dm_done_n1", {31'd0, bus.dm_done}, 32'd0);
      check("ld_stall_n1", {31'd0, bus.stall_mem}, 32'd1);
      tick();
      check("ld_dm_done_n2", {31'd0, bus.dm_done}, 32'd1);
      check("ld_dm_rdata_n2", bus.dm_rdata, 32'hDEADBEEF);
      check("ld_stall_n2", {31'd0, bus.stall_mem}, 32'd0);
      check("ld_mem_req_n2", {31'd0, bus.mem_req}, 32'd0);
      bus.dm_req = 1'b0;
      tick();
      check("ld_dm_done_n3", {31'd0, bus.dm_done}, 32'd0);
      check("ld_mem_req_n3", {31'd0, bus.mem_req}, 32'd0);

      // Store with three wait states
      bus.mem_ready = 1'b0;
      bus.dm_req    = 1'b1;
      bus.dm_rw     = 1'b1;
      bus.dm_width  = 1'b1;
      bus.dm_addr   = 32'h200;
      bus.dm_wdata  = 32'h12345678;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("st_mem_req", {31'd0, bus.mem_req}, 32'd1);
         check("st_mem_addr", bus.mem_addr, 32'h200);
         check("st_mem_wdata", bus.mem_wdata, 32'h12345678);
         check("st_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
         check("st_mem_width", {31'd0, bus.mem_width}, 32'd1);
         check("st_dm_done_wait", {31'd0, bus.dm_done}, 32'd0);
         if (i == 3) bus.mem_ready = 1'b1;
         tick();
      end
      check("st_dm_done", {31'd0, bus.dm_done}, 32'd1);
      check("st_mem_req_clr", {31'd0, bus.mem_req}, 32'd0);
      bus.dm_req   = 1'b0;
      bus.dm_rw    = 1'b0;
      bus.dm_width = 1'b0;
      tick();
      check("st_dm_done_pulse", {31'd0, bus.dm_done}, 32'd0);

      // Flush during an in-flight fetch
      bus.mem_ready = 1'b0;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h40;
      #1;
      check("fl_stall_fetch", {31'd0, bus.stall_fetch}, 32'd1);
      tick();
      check("fl_mem_req", {31'd0, bus.mem_req}, 32'd1);
      check("fl_mem_addr", bus.mem_addr, 32'h40);
      check("fl_state_busy_if", {30'd0, dut.state_q}, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush     = 1'b0;
      bus.mem_rdata = 32'hAAAA5555;
      bus.mem_ready = 1'b1;
      check("fl_mem_req_held", {31'd0, bus.mem_req}, 32'd1);
      tick();
      check("fl_if_done_supp", {31'd0, bus.if_done}, 32'd0);
      check("fl_if_rdata_kept", bus.if_rdata, 32'h0);
      check("fl_mem_req_clr", {31'd0, bus.mem_req}, 32'd0);
      check("fl_state_idle", {30'd0, dut.state_q}, 32'd0);
      bus.if_addr   = 32'h80;
      bus.mem_rdata = 32'h80808080;
      tick();
      check("fl2_mem_req", {31'd0, bus.mem_req}, 32'd1);
      check("fl2_mem_addr", bus.mem_addr, 32'h80);
      check("fl2_if_done_n1", {31'd0, bus.if_done}, 32'd0);
      tick();
      check("fl2_if_done", {31'd0, bus.if_done}, 32'd1);
      check("fl2_if_rdata", bus.if_rdata, 32'h80808080);
      check("fl2_stall_fetch", {31'd0, bus.stall_fetch}, 32'd0);
      bus.if_req = 1'b0;
      tick();
      check("fl2_if_done_pulse", {31'd0, bus.if_done}, 32'd0);

      // Flush in IDLE blocks the fetch grant for that cycle only
      bus.if_req  = 1'b1;
      bus.if_addr = 32'hC0;
      bus.flush   = 1'b1;
      tick();
      check("fi_no_grant", {31'd0, bus.mem_req}, 32'd0);
      bus.flush = 1'b0;
      tick();
      check("fi_grant", {31'd0, bus.mem_req}, 32'd1);
      check("fi_grant_addr", bus.mem_addr, 32'hC0);
      tick();
      check("fi_if_done", {31'd0, bus.if_done}, 32'd1);
      bus.if_req = 1'b0;
      tick();

      // Starvation: flush pulses in each dm_done cycle keep fetch out until the counter saturates
      bus.mem_rdata = 32'h5A5A0003;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h300;
      bus.dm_req    = 1'b1;
      bus.dm_addr   = 32'h400;
      #1;
      check("sv_stall_fetch", {31'd0, bus.stall_fetch}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("sv_dm_grant_addr", bus.mem_addr, 32'h400);
         check("sv_starve_cnt", {28'd0, dut.starve_q}, k);
         tick();
         check("sv_dm_done", {31'd0, bus.dm_done}, 32'd1);
         bus.flush = 1'b1;
         tick();
         check("sv_idle_no_grant", {31'd0, bus.mem_req}, 32'd0);
         bus.flush = 1'b0;
      end
      check("sv_starve_sat", {28'd0, dut.starve_q}, 32'd4);
      tick();
      check("sv_if_grant_addr", bus.mem_addr, 32'h300);
      check("sv_if_grant_state", {30'd0, dut.state_q}, 32'd1);
      check("sv_starve_clr", {28'd0, dut.starve_q}, 32'd0);
      tick();
      check("sv_if_done", {31'd0, bus.if_done}, 32'd1);
      check("sv_if_rdata", bus.if_rdata, 32'h5A5A0003);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      tick();
      check("sv_idle_after", {31'd0, bus.mem_req}, 32'd0);

      // Reset in the middle of a data access
      bus.mem_ready = 1'b0;
      bus.dm_req    = 1'b1;
      bus.dm_addr   = 32'h500;
      tick();
      check("rm_mem_req", {31'd0, bus.mem_req}, 32'd1);
      check("rm_state_busy_dm", {30'd0, dut.state_q}, 32'd2);
      rst        = 1'b1;
      bus.dm_req = 1'b0;
      tick();
      check("rm_mem_req_clr", {31'd0, bus.mem_req}, 32'd0);
      check("rm_state_idle", {30'd0, dut.state_q}, 32'd0);
      check("rm_dm_done", {31'd0, bus.dm_done}, 32'd0);
      check("rm_starve", {28'd0, dut.starve_q}, 32'd0);
      rst           = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      check("rm_no_done_1", {31'd0, bus.dm_done}, 32'd0);
      tick();
      check("rm_no_done_2", {31'd0, bus.dm_done}, 32'd0);
      check("rm_mem_req_idle", {31'd0, bus.mem_req}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
